// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant, one outstanding slave cycle, and a
// watchdog that aborts a silent slave with ERR_DATA + err so every master request completes.
module wb_arbiter_2m #(
   parameter int unsigned       ADDR_W   = 5,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       TO_W     = 8,
   parameter int unsigned       TIMEOUT  = 200,
   parameter logic [DATA_W-1:0] ERR_DATA = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic              m0_sel_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic              m1_sel_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic              s_sel_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [DATA_W-1:0] s_dat_o,
   input  logic [DATA_W-1:0] s_dat_i,
   input  logic              s_ack_i,
   output logic              timeout_flag_o,
   input  logic              timeout_clr_i
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                   r_state, w_state_d;
   logic [1:0]               r_pend;
   logic [1:0]               r_lat_we, r_lat_sel;
   logic [1:0][ADDR_W-1:0]   r_lat_adr;
   logic [1:0][DATA_W-1:0]   r_lat_dat;
   logic [1:0][DATA_W-1:0]   r_mdat;
   logic                     r_gnt, r_last, r_err, r_cyc, r_we, r_sel, r_flag;
   logic [ADDR_W-1:0]        r_adr;
   logic [DATA_W-1:0]        r_dat;
   logic [TO_W-1:0]          r_cnt;
   logic                     w_grant, w_gnt_sel, w_done_ack, w_done_to, w_timeout, w_resp;

   always_ff @(posedge clk) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   always_comb begin
      w_state_d  = r_state;
      w_grant    = 1'b0;
      w_gnt_sel  = r_gnt;
      w_done_ack = 1'b0;
      w_done_to  = 1'b0;
      w_timeout  = (r_cnt == TO_W'(TIMEOUT - 1));
      unique case (r_state)
         StIdle: begin
            if (|r_pend) begin
               w_grant   = 1'b1;
               // On a tie the master that did not win last time goes first
               w_gnt_sel = (r_pend == 2'b11) ? ~r_last : r_pend[1];
               w_state_d = StBusy;
            end
         end
         StBusy: begin
            if (s_ack_i) begin
               w_done_ack = 1'b1;
               w_state_d  = StResp;
            end else if (w_timeout) begin
               w_done_to = 1'b1;
               w_state_d = StResp;
            end
         end
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend    <= '0;
         r_lat_we  <= '0;
         r_lat_sel <= '0;
         r_lat_adr <= '0;
         r_lat_dat <= '0;
         r_mdat    <= '0;
         r_gnt     <= 1'b0;
         r_last    <= 1'b1;
         r_err     <= 1'b0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_cnt     <= '0;
         r_flag    <= 1'b0;
      end else begin
         if (m0_stb_i && !r_pend[0]) begin
            r_pend[0]    <= 1'b1;
            r_lat_we[0]  <= m0_we_i;
            r_lat_sel[0] <= m0_sel_i;
            r_lat_adr[0] <= m0_adr_i;
            r_lat_dat[0] <= m0_dat_i;
         end
         if (m1_stb_i && !r_pend[1]) begin
            r_pend[1]    <= 1'b1;
            r_lat_we[1]  <= m1_we_i;
            r_lat_sel[1] <= m1_sel_i;
            r_lat_adr[1] <= m1_adr_i;
            r_lat_dat[1] <= m1_dat_i;
         end
         if (w_grant) begin
            r_gnt  <= w_gnt_sel;
            r_last <= w_gnt_sel;
            r_cyc  <= 1'b1;
            r_we   <= r_lat_we[w_gnt_sel];
            r_sel  <= r_lat_sel[w_gnt_sel];
            r_adr  <= r_lat_adr[w_gnt_sel];
            r_dat  <= r_lat_dat[w_gnt_sel];
            r_cnt  <= '0;
         end
         if (r_state == StBusy) r_cnt <= r_cnt + 1'b1;
         if (w_done_ack) begin
            r_cyc         <= 1'b0;
            r_mdat[r_gnt] <= s_dat_i;
         end
         if (w_done_to) begin
            r_cyc         <= 1'b0;
            r_mdat[r_gnt] <= ERR_DATA;
            r_err         <= 1'b1;
         end
         if (r_state == StResp) begin
            r_pend[r_gnt] <= 1'b0;
            r_err         <= 1'b0;
         end
         if (w_done_to)          r_flag <= 1'b1;
         else if (timeout_clr_i) r_flag <= 1'b0;
      end
   end

   assign w_resp         = (r_state == StResp);
   assign m0_ack_o       = w_resp && !r_gnt;
   assign m1_ack_o       = w_resp && r_gnt;
   assign m0_err_o       = m0_ack_o && r_err;
   assign m1_err_o       = m1_ack_o && r_err;
   assign m0_dat_o       = r_mdat[0];
   assign m1_dat_o       = r_mdat[1];
   assign s_cyc_o        = r_cyc;
   assign s_stb_o        = r_cyc;
   assign s_we_o         = r_we;
   assign s_sel_o        = r_sel;
   assign s_adr_o        = r_adr;
   assign s_dat_o        = r_dat;
   assign timeout_flag_o = r_flag;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m (TIMEOUT=4): single read, ties, round-robin,
// watchdog abort, ack on the last watchdog cycle and reset during a slave cycle.
module tb_wb_arbiter_2m;

   logic       clk = 1'b0;
   logic       reset;
   logic       m0_stb_i, m0_we_i, m0_sel_i, m1_stb_i, m1_we_i, m1_sel_i;
   logic [4:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [7:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic       s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_ack_i;
   logic       timeout_flag_o, timeout_clr_i;

   int n_checks = 0;
   int n_errors = 0;

   wb_arbiter_2m #(
      .ADDR_W   (5),
      .DATA_W   (8),
      .TO_W     (8),
      .TIMEOUT  (4),
      .ERR_DATA (8'hFF)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .m0_stb_i       (m0_stb_i),
      .m0_we_i        (m0_we_i),
      .m0_sel_i       (m0_sel_i),
      .m0_adr_i       (m0_adr_i),
      .m0_dat_i       (m0_dat_i),
      .m0_dat_o       (m0_dat_o),
      .m0_ack_o       (m0_ack_o),
      .m0_err_o       (m0_err_o),
      .m1_stb_i       (m1_stb_i),
      .m1_we_i        (m1_we_i),
      .m1_sel_i       (m1_sel_i),
      .m1_adr_i       (m1_adr_i),
      .m1_dat_i       (m1_dat_i),
      .m1_dat_o       (m1_dat_o),
      .m1_ack_o       (m1_ack_o),
      .m1_err_o       (m1_err_o),
      .s_cyc_o        (s_cyc_o),
      .s_stb_o        (s_stb_o),
      .s_we_o         (s_we_o),
      .s_sel_o        (s_sel_o),
      .s_adr_o        (s_adr_o),
      .s_dat_o        (s_dat_o),
      .s_dat_i        (s_dat_i),
      .s_ack_i        (s_ack_i),
      .timeout_flag_o (timeout_flag_o),
      .timeout_clr_i  (timeout_clr_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int   n_txn, issued, cnt0, cnt1, cnt;
      logic saw0, saw1, acc;

      reset = 1'b1;
      m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = '0; m0_dat_i = '0;
      m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = '0; m1_dat_i = '0;
      s_dat_i = '0; s_ack_i = 0; timeout_clr_i = 0;
      tick();
      tick();
      chk("rst_cyc", s_cyc_o, 0);
      chk("rst_stb", s_stb_o, 0);
      chk("rst_ack0", m0_ack_o, 0);
      chk("rst_ack1", m1_ack_o, 0);
      chk("rst_err0", m0_err_o, 0);
      chk("rst_dat0", m0_dat_o, 0);
      chk("rst_dat1", m1_dat_o, 0);
      chk("rst_adr", s_adr_o, 0);
      chk("rst_flag", timeout_flag_o, 0);
      reset = 1'b0;

      // Single read on M0, slave acks in the third cycle of s_cyc
      m0_adr_i = 5'h03; m0_we_i = 0; m0_sel_i = 1; m0_stb_i = 1;
      tick();
      m0_stb_i = 0;
      chk("t1_cyc_latency", s_cyc_o, 0);
      tick();
      chk("t1_cyc", s_cyc_o, 1);
      chk("t1_adr", s_adr_o, 5'h03);
      chk("t1_we", s_we_o, 0);
      chk("t1_sel", s_sel_o, 1);
      tick();
      tick();
      s_ack_i = 1; s_dat_i = 8'hA5;
      tick();
      s_ack_i = 0;
      chk("t1_ack0", m0_ack_o, 1);
      chk("t1_err0", m0_err_o, 0);
      chk("t1_ack1", m1_ack_o, 0);
      chk("t1_dat0", m0_dat_o, 8'hA5);
      chk("t1_cyc_drop", s_cyc_o, 0);
      tick();
      chk("t1_ack_pulse", m0_ack_o, 0);
      chk("t1_dat_hold", m0_dat_o, 8'hA5);

      // Simultaneous writes out of reset: M0 first, then M1; next tie back to M0
      reset = 1; tick(); reset = 0;
      m0_we_i = 1; m0_adr_i = 5'd1; m0_dat_i = 8'h11;
      m1_we_i = 1; m1_adr_i = 5'd2; m1_dat_i = 8'h22;
      m0_stb_i = 1; m1_stb_i = 1;
      tick();
      m0_stb_i = 0; m1_stb_i = 0;
      tick();
      chk("t2_first_dat", s_dat_o, 8'h11);
      chk("t2_first_adr", s_adr_o, 5'd1);
      chk("t2_first_we", s_we_o, 1);
      s_ack_i = 1;
      tick();
      s_ack_i = 0;
      chk("t2_ack0", m0_ack_o, 1);
      chk("t2_nack1", m1_ack_o, 0);
      tick();
      chk("t2_gap", s_cyc_o, 0);
      tick();
      chk("t2_second_cyc", s_cyc_o, 1);
      chk("t2_second_dat", s_dat_o, 8'h22);
      chk("t2_second_adr", s_adr_o, 5'd2);
      s_ack_i = 1;
      tick();
      s_ack_i = 0;
      chk("t2_ack1", m1_ack_o, 1);
      chk("t2_nack0", m0_ack_o, 0);
      tick();
      m0_dat_i = 8'h33; m1_dat_i = 8'h44;
      m0_stb_i = 1; m1_stb_i = 1;
      tick();
      m0_stb_i = 0; m1_stb_i = 0;
      tick();
      chk("t2_tie_dat", s_dat_o, 8'h33);
      s_ack_i = 1;
      tick();
      s_ack_i = 0;
      chk("t2_tie_ack0", m0_ack_o, 1);
      tick();
      tick();
      chk("t2_tie_second_dat", s_dat_o, 8'h44);
      s_ack_i = 1;
      tick();
      s_ack_i = 0;
      chk("t2_tie_ack1", m1_ack_o, 1);
      tick();

      // Round-robin: each master re-strobes the cycle after its ack, 10 transactions total
      m0_we_i = 0; m1_we_i = 0;
      n_txn = 0; issued = 2; cnt0 = 0; cnt1 = 0; saw0 = 0; saw1 = 0;
      m0_stb_i = 1; m1_stb_i = 1;
      tick();
      for (int c = 0; c < 300 && n_txn < 10; c++) begin
         m0_stb_i = 0; m1_stb_i = 0;
         if (saw0 && issued < 10) begin m0_stb_i = 1; issued++; end
         if (saw1 && issued < 10) begin m1_stb_i = 1; issued++; end
         saw0 = m0_ack_o; saw1 = m1_ack_o;
         if (m0_ack_o || m1_ack_o) begin
            chk("t3_order", m1_ack_o, n_txn % 2);
            if (m0_ack_o) cnt0++;
            else          cnt1++;
            n_txn++;
         end
         s_ack_i = s_cyc_o;
         s_dat_i = c[7:0];
         tick();
      end
      m0_stb_i = 0; m1_stb_i = 0; s_ack_i = 0;
      chk("t3_total", n_txn, 10);
      chk("t3_m0_count", cnt0, 5);
      chk("t3_m1_count", cnt1, 5);
      tick();

      // Watchdog abort: slave never acks
      m0_adr_i = 5'd7; m0_stb_i = 1;
      tick();
      m0_stb_i = 0;
      tick();
      cnt = 0;
      while (s_cyc_o && cnt < 20) begin
         cnt++;
         tick();
      end
      chk("t4_cyc_len", cnt, 4);
      chk("t4_ack0", m0_ack_o, 1);
      chk("t4_err0", m0_err_o, 1);
      chk("t4_dat0", m0_dat_o, 8'hFF);
      chk("t4_flag", timeout_flag_o, 1);
      chk("t4_ack1", m1_ack_o, 0);
      tick();
      chk("t4_err_pulse", m0_err_o, 0);
      chk("t4_flag_sticky", timeout_flag_o, 1);
      timeout_clr_i = 1;
      tick();
      timeout_clr_i = 0;
      chk("t4_flag_clr", timeout_flag_o, 0);

      // Ack in the final watchdog cycle wins over the abort
      m0_adr_i = 5'd9; m0_stb_i = 1;
      tick();
      m0_stb_i = 0;
      tick();
      tick();
      tick();
      tick();
      chk("t5_cyc_last", s_cyc_o, 1);
      s_ack_i = 1; s_dat_i = 8'h5A;
      tick();
      s_ack_i = 0;
      chk("t5_ack0", m0_ack_o, 1);
      chk("t5_err0", m0_err_o, 0);
      chk("t5_dat0", m0_dat_o, 8'h5A);
      chk("t5_flag", timeout_flag_o, 0);
      tick();

      // Reset two cycles into a slave cycle, with an M1 request pending
      m0_adr_i = 5'd10; m0_stb_i = 1;
      tick();
      m0_stb_i = 0;
      tick();
      chk("t6_cyc_up", s_cyc_o, 1);
      m1_adr_i = 5'd12; m1_stb_i = 1;
      tick();
      m1_stb_i = 0;
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("t6_cyc", s_cyc_o, 0);
      chk("t6_stb", s_stb_o, 0);
      chk("t6_ack0", m0_ack_o, 0);
      chk("t6_ack1", m1_ack_o, 0);
      chk("t6_dat0", m0_dat_o, 0);
      chk("t6_adr", s_adr_o, 0);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         acc = acc | m0_ack_o | m1_ack_o | s_cyc_o;
         tick();
      end
      chk("t6_quiet", acc, 0);
      m1_we_i = 1; m1_sel_i = 1; m1_adr_i = 5'd4; m1_dat_i = 8'h77; m1_stb_i = 1;
      tick();
      m1_stb_i = 0;
      tick();
      chk("t6_m1_cyc", s_cyc_o, 1);
      chk("t6_m1_adr", s_adr_o, 5'd4);
      chk("t6_m1_dat", s_dat_o, 8'h77);
      chk("t6_m1_we", s_we_o, 1);
      s_ack_i = 1; s_dat_i = 8'h3C;
      tick();
      s_ack_i = 0;
      chk("t6_m1_ack", m1_ack_o, 1);
      chk("t6_m1_err", m1_err_o, 0);
      chk("t6_m1_rdat", m1_dat_o, 8'h3C);
      chk("t6_m0_noack", m0_ack_o, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
